// File: rtl/caminho_dados_if.sv
// Control/data bundle between the controle FSM (master) and the datapath (slave).
interface caminho_dados_if #(parameter int unsigned W = 8);
    logic [W-1:0] Dado;
    logic         EnA;
    logic         EnB;
    logic         Sel;
    logic [1:0]   Op;
    logic [1:0]   OpReg;
    logic         Fim;
    logic [W-1:0] Resultado;
    logic         Valido;
    logic         Pronto;
    logic         Ovf;
    logic         Perdido;
    logic         Erro;

    modport master (
        output Dado, EnA, EnB, Sel, Op, OpReg, Fim, Pronto,
        input  Resultado, Valido, Ovf, Perdido, Erro
    );

    modport slave (
        input  Dado, EnA, EnB, Sel, Op, OpReg, Fim, Pronto,
        output Resultado, Valido, Ovf, Perdido, Erro
    );
endinterface

// File: rtl/caminho_dados.sv
// Operand registers, ALU and accumulator R, with a valid/ready result register
// plus sticky overflow, drop and illegal-control flags.
module caminho_dados #(
    parameter int unsigned W = 8
) (
    input logic            clk,
    input logic            rst,
    caminho_dados_if.slave bus
);

    logic signed [W-1:0] a_q, b_q, r_q, res_q;
    logic                valid_q, ovf_q, perdido_q, erro_q, acc_q;

    logic signed [W-1:0] opnd2, alu, r_next;
    logic signed [W:0]   ext_a, ext_o, sum, diff;
    logic                ovf_c, acc_en, cyc_ovf, illegal_op, out_free;

    // ALU at W+1 bits; overflow when the two top bits of the result disagree
    always_comb begin
        opnd2      = bus.Sel ? r_q : b_q;
        ext_a      = {a_q[W-1], a_q};
        ext_o      = {opnd2[W-1], opnd2};
        sum        = ext_a + ext_o;
        diff       = ext_a - ext_o;
        alu        = '0;
        ovf_c      = 1'b0;
        illegal_op = 1'b0;
        case (bus.Op)
            2'b00: alu = a_q;
            2'b01: begin
                alu   = sum[W-1:0];
                ovf_c = sum[W] ^ sum[W-1];
            end
            2'b10: begin
                alu   = diff[W-1:0];
                ovf_c = diff[W] ^ diff[W-1];
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // Next R; only ALU-writing updates contribute to the overflow accumulator
    always_comb begin
        r_next = r_q;
        acc_en = 1'b0;
        case (bus.OpReg)
            2'b00: r_next = r_q;
            2'b01: begin
                r_next = alu;
                acc_en = 1'b1;
            end
            2'b10: begin
                r_next = alu >>> 1;
                acc_en = 1'b1;
            end
            default: r_next = '0;
        endcase
        cyc_ovf  = ovf_c & acc_en;
        out_free = !valid_q || bus.Pronto;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            perdido_q <= 1'b0;
            erro_q    <= 1'b0;
            acc_q     <= 1'b0;
        end else begin
            if (bus.EnA) a_q <= bus.Dado;
            if (bus.EnB) b_q <= bus.Dado;
            r_q   <= r_next;
            acc_q <= bus.EnA ? 1'b0 : (acc_q | cyc_ovf);

            // Output register: refill takes priority over the consume-clear
            if (bus.Fim && out_free) begin
                res_q   <= r_next;
                ovf_q   <= acc_q | cyc_ovf;
                valid_q <= 1'b1;
            end else if (bus.Fim) begin
                perdido_q <= 1'b1;
            end else if (valid_q && bus.Pronto) begin
                valid_q <= 1'b0;
            end

            if ((bus.EnA && bus.EnB) || illegal_op) erro_q <= 1'b1;
        end
    end

    assign bus.Resultado = res_q;
    assign bus.Valido    = valid_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Perdido   = perdido_q;
    assign bus.Erro      = erro_q;

endmodule

// File: tb/tb_caminho_dados.sv
// Directed bench for caminho_dados: instruction sequences with hand-computed results.
module tb_caminho_dados;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    caminho_dados_if #(.W(8)) bus ();

    caminho_dados #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Present one control word, let one rising edge pass, settle #1 after it
    task automatic step(input logic [7:0] d, input logic ena, input logic enb,
                        input logic sel, input logic [1:0] op, input logic [1:0] opreg,
                        input logic fim);
        bus.Dado  = d;
        bus.EnA   = ena;
        bus.EnB   = enb;
        bus.Sel   = sel;
        bus.Op    = op;
        bus.OpReg = opreg;
        bus.Fim   = fim;
        @(posedge clk);
        #1;
        bus.EnA = 1'b0;
        bus.EnB = 1'b0;
        bus.Fim = 1'b0;
        bus.Op  = 2'b00;
        bus.OpReg = 2'b00;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    // Instrucao 0: R=A-B, then result A+R
    task automatic instr0(input logic [7:0] a, input logic [7:0] b);
        step(a, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(b, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1);
    endtask

    // Instrucao 1: R=A+B, R=A+R, result (A+R)>>>1; Pronto forced to p_last at Fim
    task automatic instr1(input logic [7:0] a, input logic [7:0] b, input logic p_last);
        step(a, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(b, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0);
        bus.Pronto = p_last;
        step(8'h00, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1);
    endtask

    initial begin
        bus.Dado = '0; bus.EnA = 1'b0; bus.EnB = 1'b0; bus.Sel = 1'b0;
        bus.Op = 2'b00; bus.OpReg = 2'b00; bus.Fim = 1'b0; bus.Pronto = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", bus.Resultado, 8'h00);
        chk("rst_val", 8'(bus.Valido), 8'h00);
        chk("rst_ovf", 8'(bus.Ovf), 8'h00);
        chk("rst_perd", 8'(bus.Perdido), 8'h00);
        chk("rst_erro", 8'(bus.Erro), 8'h00);
        rst = 1'b1;
        idle();

        instr0(8'd10, 8'd3);
        chk("i0_res", bus.Resultado, 8'd17);
        chk("i0_val", 8'(bus.Valido), 8'h01);
        chk("i0_ovf", 8'(bus.Ovf), 8'h00);
        idle();
        chk("i0_consumed", 8'(bus.Valido), 8'h00);

        instr1(8'd10, 8'd3, 1'b1);
        chk("i1_res", bus.Resultado, 8'd16);
        chk("i1_val", 8'(bus.Valido), 8'h01);

        instr1(8'hFA, 8'd4, 1'b1);
        chk("neg_res", bus.Resultado, 8'hF9);
        chk("neg_ovf", 8'(bus.Ovf), 8'h00);

        instr1(8'd100, 8'd50, 1'b1);
        chk("ovf_res", bus.Resultado, 8'h2F);
        chk("ovf_flag", 8'(bus.Ovf), 8'h01);
        instr1(8'd1, 8'd1, 1'b1);
        chk("noovf_res", bus.Resultado, 8'h02);
        chk("noovf_flag", 8'(bus.Ovf), 8'h00);
        chk("noovf_erro", 8'(bus.Erro), 8'h00);
        idle();
        chk("drain_val", 8'(bus.Valido), 8'h00);

        // Backpressure: hold, drop, then back-to-back refill on accept
        bus.Pronto = 1'b0;
        instr1(8'd10, 8'd3, 1'b0);
        chk("bp1_res", bus.Resultado, 8'd16);
        chk("bp1_perd", 8'(bus.Perdido), 8'h00);
        instr1(8'hFA, 8'd4, 1'b0);
        chk("bp2_held", bus.Resultado, 8'd16);
        chk("bp2_val", 8'(bus.Valido), 8'h01);
        chk("bp2_perd", 8'(bus.Perdido), 8'h01);
        instr1(8'd1, 8'd1, 1'b1);
        chk("bp3_res", bus.Resultado, 8'h02);
        chk("bp3_val", 8'(bus.Valido), 8'h01);
        chk("bp3_perd", 8'(bus.Perdido), 8'h01);
        idle();
        chk("bp3_drain", 8'(bus.Valido), 8'h00);

        // Reset mid-instruction: asynchronous clear, no result follows
        step(8'd100, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(8'd50, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_res", bus.Resultado, 8'h00);
        chk("mid_perd", 8'(bus.Perdido), 8'h00);
        chk("mid_val", 8'(bus.Valido), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        chk("post_val", 8'(bus.Valido), 8'h00);
        instr0(8'd10, 8'd3);
        chk("post_res", bus.Resultado, 8'd17);
        chk("post_ovf", 8'(bus.Ovf), 8'h00);
        chk("post_erro", 8'(bus.Erro), 8'h00);

        // Illegal Op sets sticky Erro
        step(8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        chk("ill_erro", 8'(bus.Erro), 8'h01);
        idle();
        idle();
        chk("ill_sticky", 8'(bus.Erro), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
